axi_slave_arb_r: RTL

//  AXI read-data (R) channel arbiter between two slaves, upstream of the R-channel master demux.
//  - Round-robin picks one slave R stream; grant is locked for the whole burst, until the RLAST handshake.
//  - Beats pass through a 2-entry buffer, so downstream rready never reaches slave RREADY combinationally.
//  - Output (rid, rdata, rresp, rlast, rvalid, with rready back) feeds the demux, which steers by rid.

---
 rtl/axi_pkg.sv | 30 +++
 rtl/axi_r_skid_fifo.sv | 43 ++++
 rtl/axi_slave_arb_r.sv | 111 +++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI R-channel types: IDs, response codes, beat bundle, arbiter states.
package axi_pkg;

    localparam int ID_W   = 8;
    localparam int DATA_W = 32;

    localparam logic [ID_W-1:0] M0_ID = 8'h01;
    localparam logic [ID_W-1:0] M1_ID = 8'h02;

    typedef enum logic [1:0] {
        OKAY,
        EXOKAY,
        SLVERR,
        DECERR
    } rresp_e;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        rresp_e            resp;
        logic              last;
    } r_beat_t;

    typedef enum logic [1:0] {
        IDLE,
        GNT_S0,
        GNT_S1
    } arb_state_e;

endpackage

// File: rtl/axi_r_skid_fifo.sv
// Two-entry R beat buffer; decouples downstream ready from slave ready.
module axi_r_skid_fifo
    import axi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  r_beat_t    din,
    output r_beat_t    head,
    output logic [1:0] count
);

    r_beat_t mem [2];
    logic    wr_ptr;
    logic    rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/axi_slave_arb_r.sv
// Two-slave R-channel arbiter: round-robin, burst-locked grant, buffered output.
module axi_slave_arb_r #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   s0_RID,
    input  logic [DATA_W-1:0] s0_RDATA,
    input  logic [1:0]        s0_RRESP,
    input  logic              s0_RLAST,
    input  logic              s0_RVALID,
    output logic              s0_RREADY,
    input  logic [ID_W-1:0]   s1_RID,
    input  logic [DATA_W-1:0] s1_RDATA,
    input  logic [1:0]        s1_RRESP,
    input  logic              s1_RLAST,
    input  logic              s1_RVALID,
    output logic              s1_RREADY,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready
);

    import axi_pkg::*;

    arb_state_e state;
    logic       rr_next;
    logic [1:0] buf_count;
    logic       room;
    logic       push;
    logic       pop;
    r_beat_t    in_beat;
    r_beat_t    head;

    assign room      = (buf_count != 2'd2);
    assign s0_RREADY = (state == GNT_S0) && room;
    assign s1_RREADY = (state == GNT_S1) && room;

    assign push = (s0_RVALID & s0_RREADY)
                | (s1_RVALID & s1_RREADY);
    assign pop  = rvalid & rready;

    always_comb begin
        in_beat = '0;
        if (state == GNT_S1) begin
            in_beat.id   = s1_RID;
            in_beat.data = s1_RDATA;
            in_beat.resp = rresp_e'(s1_RRESP);
            in_beat.last = s1_RLAST;
        end else begin
            in_beat.id   = s0_RID;
            in_beat.data = s0_RDATA;
            in_beat.resp = rresp_e'(s0_RRESP);
            in_beat.last = s0_RLAST;
        end
    end

    // Grant is only released by the RLAST handshake of the owning slave.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_next <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_RVALID && s1_RVALID) begin
                        state <= rr_next ? GNT_S1 : GNT_S0;
                    end else if (s0_RVALID) begin
                        state <= GNT_S0;
                    end else if (s1_RVALID) begin
                        state <= GNT_S1;
                    end
                end
                GNT_S0: begin
                    if (s0_RVALID && s0_RREADY && s0_RLAST) begin
                        state   <= IDLE;
                        rr_next <= 1'b1;
                    end
                end
                GNT_S1: begin
                    if (s1_RVALID && s1_RREADY && s1_RLAST) begin
                        state   <= IDLE;
                        rr_next <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    axi_r_skid_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_beat),
        .head  (head),
        .count (buf_count)
    );

    assign rvalid = (buf_count != 2'd0);
    assign rid    = head.id;
    assign rdata  = head.data;
    assign rresp  = head.resp;
    assign rlast  = head.last;

endmodule
